// File: rtl/sad_search_ctrl.sv
// Block-matching search controller: runs one SAD per candidate on the shared core, keeps min SAD + index.
// Optional early exit when the best SAD drops below thr_i: define SAD_THRESH_EN.
module sad_search_ctrl #(
    parameter int BLK_PIX   = 256,
    parameter int N_CAND    = 16,
    parameter int CAND_STEP = 1,
    parameter int AW        = 16,
    parameter int SAD_W     = 32,
    parameter int IW        = (N_CAND > 1) ? $clog2(N_CAND) : 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [SAD_W-1:0] best_sad_o,
    output logic [IW-1:0]    best_idx_o,
    output logic [AW-1:0]    cur_addr_o,
    input  logic [7:0]       cur_data_i,
    output logic [AW-1:0]    ref_addr_o,
    input  logic [7:0]       ref_data_i,
    output logic             sad_clr_o,
    output logic             sad_enb_o,
    output logic [7:0]       sad_dta_o,
    output logic [7:0]       sad_dtb_o,
    input  logic [SAD_W-1:0] sad_dt_i,
`ifdef SAD_THRESH_EN
    input  logic [SAD_W-1:0] thr_i,
    output logic             early_o,
`endif
    output logic [2:0]       fsm_state
);

    localparam int PW = (BLK_PIX > 1) ? $clog2(BLK_PIX) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(BLK_PIX - 1);
    localparam logic [IW-1:0] C_LAST = IW'(N_CAND - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        STREAM  = 3'd2,
        WAIT    = 3'd3,
        COMPARE = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t          state, state_next;
    logic [PW-1:0]   p;
    logic [PW-1:0]   p_issue;
    logic [IW-1:0]   c;
    logic [AW-1:0]   ref_base;
    logic            sad_lt;
    logic            thresh_hit;

    // Handshake: start_i is a level sampled only in IDLE (ignored otherwise, never queued);
    // done_o is a single-cycle pulse, and the best_* outputs stay valid from done_o until the next accepted start.
    assign sad_lt = (sad_dt_i < best_sad_o);

`ifdef SAD_THRESH_EN
    logic [SAD_W-1:0] new_best;
    logic             early;
    assign new_best   = sad_lt ? sad_dt_i : best_sad_o;
    assign thresh_hit = (new_best < thr_i);
    assign early_o    = early;
`else
    assign thresh_hit = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state      <= IDLE;
            p          <= '0;
            c          <= '0;
            ref_base   <= '0;
            best_sad_o <= '0;
            best_idx_o <= '0;
`ifdef SAD_THRESH_EN
            early      <= 1'b0;
`endif
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        c          <= '0;
                        ref_base   <= '0;
                        best_sad_o <= '1;
                        best_idx_o <= '0;
`ifdef SAD_THRESH_EN
                        early      <= 1'b0;
`endif
                    end
                end
                CLEAR:  p <= '0;
                STREAM: if (p != P_LAST) p <= p + PW'(1);
                COMPARE: begin
                    if (sad_lt) begin
                        best_sad_o <= sad_dt_i;
                        best_idx_o <= c;
                    end
`ifdef SAD_THRESH_EN
                    if (thresh_hit) early <= 1'b1;
`endif
                    if (c != C_LAST && !thresh_hit) begin
                        c        <= c + IW'(1);
                        ref_base <= ref_base + AW'(CAND_STEP);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_i) state_next = CLEAR;
            CLEAR:   state_next = STREAM;
            STREAM:  if (p == P_LAST) state_next = WAIT;
            WAIT:    state_next = COMPARE;
            COMPARE: state_next = (c == C_LAST || thresh_hit) ? DONE : CLEAR;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // While streaming pixel p, the RAMs are already fetching pixel p+1; the last pixel's address holds.
    always_comb begin
        p_issue    = (p == P_LAST) ? p : p + PW'(1);
        cur_addr_o = '0;
        ref_addr_o = '0;
        case (state)
            CLEAR:  ref_addr_o = ref_base;
            STREAM: begin
                cur_addr_o = AW'(p_issue);
                ref_addr_o = ref_base + AW'(p_issue);
            end
            default: ;
        endcase
    end

    assign busy_o    = (state != IDLE);
    assign done_o    = (state == DONE);
    assign sad_clr_o = (state == CLEAR);
    assign sad_enb_o = (state == STREAM);
    assign sad_dta_o = cur_data_i;
    assign sad_dtb_o = ref_data_i;
    assign fsm_state = state;

endmodule
